// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control block.
// Holds the FSM state encoding (also the debug `state` code), the supported
// opcodes, and the alu_op / alu_src_b / pc_src selector encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU  = 2'd0;
    localparam logic [1:0] PCSRC_AOUT = 2'd1;
    localparam logic [1:0] PCSRC_JMP  = 2'd2;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// master: the controller (drives strobes/selects, reads run/opcode/mem_ready).
// slave : the datapath/memory side (the reverse).
interface mips_multicycle_ctrl_if;
    logic       run;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic       bus_err;
    logic [3:0] state;

    modport master (
        input  run, opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal_op, bus_err, state
    );

    modport slave (
        output run, opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal_op, bus_err, state
    );
endinterface

// File: rtl/mips_mem_watchdog.sv
// Memory-access watchdog for the multicycle MIPS controller.
// Counts cycles spent stalled (mem_ready=0) in a memory state and flags an
// abort once MAX_WAIT stall cycles have already elapsed.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_mem_i       controller is in FETCH, MEM_READ or MEM_WRITE
//   mem_ready_i    memory completes the access this cycle
//   bus_err_o      abort this cycle (combinational, one-cycle pulse)
module mips_mem_watchdog #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_mem_i,
    input  logic mem_ready_i,
    output logic bus_err_o
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // A ready in the limit cycle completes the access instead of aborting.
    assign bus_err_o = in_mem_i && !mem_ready_i && (cnt_q == MAX_CNT);

    // Every exit from a memory state needs mem_ready or an abort, so clearing
    // on those (and outside memory states) makes each entry start at zero,
    // including MEM_WRITE -> FETCH back-to-back.
    always_comb begin
        if (!in_mem_i || mem_ready_i || bus_err_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory and
// writeback over a shared datapath, one state per cycle. Memory states stall
// on mem_ready; a watchdog (mips_mem_watchdog) aborts a hung access to IDLE.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        mips_multicycle_ctrl_if.master: run/opcode/mem_ready in,
//              datapath strobes, selects, illegal_op, bus_err, state out
// Optional build macro MC_PERF_CNT_EN adds:
//   cycle_cnt  non-IDLE cycle count (wraps at 2^32)
//   instr_cnt  completed-instruction count (wraps at 2^32)
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           instr_cnt
`endif
);

    state_e state_q;
    state_e state_d;
    state_e end_state;
    logic   in_mem;
    logic   bus_err;
    logic   illegal;

    assign in_mem = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                    (state_q == S_MEM_WRITE);

    mips_mem_watchdog #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .in_mem_i    (in_mem),
        .mem_ready_i (bus.mem_ready),
        .bus_err_o   (bus_err)
    );

    // run is only sampled at instruction boundaries.
    assign end_state = bus.run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_IDLE:      if (bus.run) state_d = S_FETCH;
            S_FETCH: begin
                if (bus_err)            state_d = S_IDLE;
                else if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDI_EXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = end_state;
                    end
                endcase
            end
            // Only lw/sw reach MEM_ADDR, so sw vs. anything else suffices.
            S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (bus_err)            state_d = S_IDLE;
                else if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                if (bus_err)            state_d = S_IDLE;
                else if (bus.mem_ready) state_d = end_state;
            end
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = end_state;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode from the registered state; FETCH's ir_write/pc_write are
    // the only terms qualified by mem_ready.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_RT;
        bus.alu_op        = ALU_ADD;
        bus.pc_src        = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE:    bus.alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = PCSRC_AOUT;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PCSRC_JMP;
            end
            S_ADDI_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB:   bus.reg_write = 1'b1;
            default: ;
        endcase
    end

    assign bus.illegal_op = illegal;
    assign bus.bus_err    = bus_err;
    assign bus.state      = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instr_cnt_q;
    logic        instr_end;

    assign instr_end = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) ||
                       (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                       (state_q == S_ADDI_WB) ||
                       ((state_q == S_MEM_WRITE) && bus.mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_IDLE) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (instr_end)         instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
